flow_control_sender: RTL and testbench

Sender-side link flow control, paired with the NoC receiver flow control stage. It takes flits from local processing (router output or NI) over a valid/ready handshake and drives them onto a link. Link pacing is either elastic (receiver ready) or credit-based (receiver credit-update pulses against a local credit counter). An optional output stage registers the link drive.

---
 rtl/flow_control_sender.sv | 188 ++++++++++++++++++
 tb/tb_flow_control_sender.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_control_sender.sv
// flow_control_sender
// Sender side of a NoC link. Flits arrive from local logic over a
// valid/ready handshake and are driven onto the link. The link is paced
// either by credits (back_notify is a credit-return pulse counted against
// a local credit counter) or elastically (back_notify is the receiver's
// ready). OUT_REG selects a registered or combinational link drive.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   data_in      upstream flit
//   valid_in     upstream flit valid
//   ready_out    upstream accept; a transfer is valid_in & ready_out
//   data_out     link flit
//   valid_out    link valid
//   back_notify  receiver ready (elastic) or credit-update pulse (credits)
//   credit_cnt   credits currently held (0 in elastic mode)
//   cr_err       sticky credit-overflow flag, cleared only by rst

package flow_control_pkg;
  typedef enum logic {
    FLOW_CONTROL_CREDITS = 1'b0,
    FLOW_CONTROL_ELASTIC = 1'b1
  } flow_control_type_e;
endpackage

module flow_control_sender
  import flow_control_pkg::*;
#(
  parameter int                 LINK_WIDTH = 16,
  parameter flow_control_type_e FC_TYPE    = FLOW_CONTROL_CREDITS,
  parameter int                 CREDITS    = 3,
  parameter int                 OUT_REG    = 1,
  parameter int                 CNT_W      = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LINK_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [LINK_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  back_notify,
  output logic [CNT_W-1:0]      credit_cnt,
  output logic                  cr_err
);

  if (FC_TYPE == FLOW_CONTROL_CREDITS) begin : gCredits

    logic [CNT_W-1:0] creditCnt_q, creditCnt_d;
    logic             crErr_q, crErr_d;
    logic             readyInt;
    logic             fire;

    // A credit returned in the same cycle cannot be spent yet, so ready
    // depends only on the registered count.
    assign readyInt = (creditCnt_q != '0) & ~rst;
    assign fire     = valid_in & readyInt;

    // Count moves by -fire +back_notify. A return while already full has
    // nowhere to go: the count saturates and the error latches.
    always_comb begin
      creditCnt_d = creditCnt_q;
      crErr_d     = crErr_q;
      if (fire && !back_notify) begin
        creditCnt_d = creditCnt_q - 1'b1;
      end else if (!fire && back_notify) begin
        if (creditCnt_q == CNT_W'(CREDITS)) begin
          crErr_d = 1'b1;
        end else begin
          creditCnt_d = creditCnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        creditCnt_q <= CNT_W'(CREDITS);
        crErr_q     <= 1'b0;
      end else begin
        creditCnt_q <= creditCnt_d;
        crErr_q     <= crErr_d;
      end
    end

    assign ready_out  = readyInt;
    assign credit_cnt = creditCnt_q;
    assign cr_err     = crErr_q;

    if (OUT_REG != 0) begin : gReg
      logic [LINK_WIDTH-1:0] linkData_q;
      logic                  linkValid_q;

      // Each accepted flit becomes a single-cycle link pulse; data holds
      // its last value between pulses.
      always_ff @(posedge clk) begin
        if (rst) begin
          linkData_q  <= '0;
          linkValid_q <= 1'b0;
        end else begin
          linkValid_q <= fire;
          if (fire) begin
            linkData_q <= data_in;
          end
        end
      end

      assign data_out  = linkData_q;
      assign valid_out = linkValid_q;
    end else begin : gComb
      assign data_out  = data_in;
      assign valid_out = fire;
    end

  end else begin : gElastic

    assign credit_cnt = '0;
    assign cr_err     = 1'b0;

    if (OUT_REG != 0) begin : gReg
      logic                  mainValid_q, mainValid_d;
      logic                  skidValid_q, skidValid_d;
      logic [LINK_WIDTH-1:0] mainData_q, mainData_d;
      logic [LINK_WIDTH-1:0] skidData_q, skidData_d;
      logic                  readyInt;
      logic                  fire;
      logic                  pop;

      // Ready comes from the skid flag only, so the upstream never sees a
      // combinational path from the receiver's ready.
      assign readyInt = ~skidValid_q & ~rst;
      assign fire     = valid_in & readyInt;
      assign pop      = mainValid_q & back_notify;

      // Main always holds the oldest flit. On a pop the skid flit (if any)
      // moves up; a skid flit implies ready was low, so no fire competes.
      always_comb begin
        mainValid_d = mainValid_q;
        mainData_d  = mainData_q;
        skidValid_d = skidValid_q;
        skidData_d  = skidData_q;
        if (pop) begin
          if (skidValid_q) begin
            mainData_d  = skidData_q;
            skidValid_d = 1'b0;
          end else begin
            mainValid_d = fire;
            if (fire) begin
              mainData_d = data_in;
            end
          end
        end else if (fire) begin
          if (!mainValid_q) begin
            mainValid_d = 1'b1;
            mainData_d  = data_in;
          end else begin
            skidValid_d = 1'b1;
            skidData_d  = data_in;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          mainValid_q <= 1'b0;
          mainData_q  <= '0;
          skidValid_q <= 1'b0;
          skidData_q  <= '0;
        end else begin
          mainValid_q <= mainValid_d;
          mainData_q  <= mainData_d;
          skidValid_q <= skidValid_d;
          skidData_q  <= skidData_d;
        end
      end

      assign ready_out = readyInt;
      assign data_out  = mainData_q;
      assign valid_out = mainValid_q;
    end else begin : gComb
      assign ready_out = back_notify & ~rst;
      assign data_out  = data_in;
      assign valid_out = valid_in;
    end

  end

endmodule

// File: tb/tb_flow_control_sender.sv
// tb_flow_control_sender
// Directed bench for flow_control_sender. Four instances share clk/rst:
// credits with registered output, credits combinational, elastic
// registered (skid buffer) and elastic passthrough.

module tb_flow_control_sender;
  import flow_control_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // credits, OUT_REG=1
  logic [15:0] crDataIn, crDataOut;
  logic        crValidIn, crReadyOut, crValidOut, crBn, crErr;
  logic [1:0]  crCnt;
  // credits, OUT_REG=0
  logic [15:0] c0DataIn, c0DataOut;
  logic        c0ValidIn, c0ReadyOut, c0ValidOut, c0Bn, c0Err;
  logic [1:0]  c0Cnt;
  // elastic, OUT_REG=1
  logic [15:0] elDataIn, elDataOut;
  logic        elValidIn, elReadyOut, elValidOut, elBn, elErr;
  logic [1:0]  elCnt;
  // elastic, OUT_REG=0
  logic [15:0] ptDataIn, ptDataOut;
  logic        ptValidIn, ptReadyOut, ptValidOut, ptBn, ptErr;
  logic [1:0]  ptCnt;

  flow_control_sender #(.LINK_WIDTH(16), .FC_TYPE(FLOW_CONTROL_CREDITS), .CREDITS(3), .OUT_REG(1)) uCr (
    .clk(clk), .rst(rst), .data_in(crDataIn), .valid_in(crValidIn), .ready_out(crReadyOut),
    .data_out(crDataOut), .valid_out(crValidOut), .back_notify(crBn), .credit_cnt(crCnt), .cr_err(crErr));

  flow_control_sender #(.LINK_WIDTH(16), .FC_TYPE(FLOW_CONTROL_CREDITS), .CREDITS(3), .OUT_REG(0)) uC0 (
    .clk(clk), .rst(rst), .data_in(c0DataIn), .valid_in(c0ValidIn), .ready_out(c0ReadyOut),
    .data_out(c0DataOut), .valid_out(c0ValidOut), .back_notify(c0Bn), .credit_cnt(c0Cnt), .cr_err(c0Err));

  flow_control_sender #(.LINK_WIDTH(16), .FC_TYPE(FLOW_CONTROL_ELASTIC), .CREDITS(3), .OUT_REG(1)) uEl (
    .clk(clk), .rst(rst), .data_in(elDataIn), .valid_in(elValidIn), .ready_out(elReadyOut),
    .data_out(elDataOut), .valid_out(elValidOut), .back_notify(elBn), .credit_cnt(elCnt), .cr_err(elErr));

  flow_control_sender #(.LINK_WIDTH(16), .FC_TYPE(FLOW_CONTROL_ELASTIC), .CREDITS(3), .OUT_REG(0)) uPt (
    .clk(clk), .rst(rst), .data_in(ptDataIn), .valid_in(ptValidIn), .ready_out(ptReadyOut),
    .data_out(ptDataOut), .valid_out(ptValidOut), .back_notify(ptBn), .credit_cnt(ptCnt), .cr_err(ptErr));

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Step to 1 ns after the next rising edge.
  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles with every input idle; returns in cycle 0 after reset.
  task automatic doReset();
    crValidIn = 1'b0; crDataIn = '0; crBn = 1'b0;
    c0ValidIn = 1'b0; c0DataIn = '0; c0Bn = 1'b0;
    elValidIn = 1'b0; elDataIn = '0; elBn = 1'b0;
    ptValidIn = 1'b0; ptDataIn = '0; ptBn = 1'b0;
    rst = 1'b1;
    advance();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    rst = 1'b1;
    crValidIn = 1'b1; crDataIn = 16'h9999; crBn = 1'b1;
    elValidIn = 1'b1; elDataIn = 16'h8888;
    advance();
    advance();
    total++; if (crReadyOut !== 1'b0) begin bad++; $display("[TB] FAIL reset_cr_ready got=%b exp=0", crReadyOut); end
    total++; if (crValidOut !== 1'b0) begin bad++; $display("[TB] FAIL reset_cr_valid got=%b exp=0", crValidOut); end
    total++; if (crDataOut !== 16'h0000) begin bad++; $display("[TB] FAIL reset_cr_data got=%h exp=0000", crDataOut); end
    total++; if (crCnt !== 2'd3) begin bad++; $display("[TB] FAIL reset_cr_cnt got=%0d exp=3", crCnt); end
    total++; if (crErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_cr_err got=%b exp=0", crErr); end
    total++; if (elReadyOut !== 1'b0) begin bad++; $display("[TB] FAIL reset_el_ready got=%b exp=0", elReadyOut); end
    total++; if (elValidOut !== 1'b0) begin bad++; $display("[TB] FAIL reset_el_valid got=%b exp=0", elValidOut); end
    total++; if (elCnt !== 2'd0) begin bad++; $display("[TB] FAIL reset_el_cnt got=%0d exp=0", elCnt); end
    crValidIn = 1'b0; crBn = 1'b0; elValidIn = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (crReadyOut !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_cr_ready got=%b exp=1", crReadyOut); end
    total++; if (elReadyOut !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_el_ready got=%b exp=1", elReadyOut); end
  endtask

  task automatic test_credit_exhaust();
    logic [15:0] flit [0:5];
    logic        expReady, expValid;
    logic [1:0]  expCnt;
    flit = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3, 16'hE4E4, 16'hF5F5};
    doReset();
    for (int k = 0; k < 6; k++) begin
      crValidIn = 1'b1;
      crDataIn  = flit[k];
      #1;
      expReady = (k < 3);
      expValid = (k >= 1 && k <= 3);
      expCnt   = (k <= 3) ? 2'(3 - k) : 2'd0;
      total++; if (crReadyOut !== expReady) begin bad++; $display("[TB] FAIL exhaust_ready c%0d got=%b exp=%b", k, crReadyOut, expReady); end
      total++; if (crValidOut !== expValid) begin bad++; $display("[TB] FAIL exhaust_valid c%0d got=%b exp=%b", k, crValidOut, expValid); end
      total++; if (crCnt !== expCnt) begin bad++; $display("[TB] FAIL exhaust_cnt c%0d got=%0d exp=%0d", k, crCnt, expCnt); end
      if (k >= 1) begin
        total++;
        if (crDataOut !== flit[(k <= 3) ? k - 1 : 2]) begin
          bad++; $display("[TB] FAIL exhaust_data c%0d got=%h exp=%h", k, crDataOut, flit[(k <= 3) ? k - 1 : 2]);
        end
      end
      advance();
    end
  endtask

  // Continues from count 0 left by test_credit_exhaust with valid_in high.
  task automatic test_credit_return();
    int pulses;
    crValidIn = 1'b1; crDataIn = 16'h1111; crBn = 1'b1;
    #1;
    total++; if (crReadyOut !== 1'b0) begin bad++; $display("[TB] FAIL return_same_cycle_ready got=%b exp=0", crReadyOut); end
    advance();
    crBn = 1'b0;
    #1;
    total++; if (crCnt !== 2'd1) begin bad++; $display("[TB] FAIL return_cnt got=%0d exp=1", crCnt); end
    total++; if (crReadyOut !== 1'b1) begin bad++; $display("[TB] FAIL return_ready got=%b exp=1", crReadyOut); end
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      advance();
      if (crValidOut === 1'b1) begin
        pulses++;
        total++; if (crDataOut !== 16'h1111) begin bad++; $display("[TB] FAIL return_data got=%h exp=1111", crDataOut); end
      end
    end
    total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL return_pulses got=%0d exp=1", pulses); end
    total++; if (crCnt !== 2'd0) begin bad++; $display("[TB] FAIL return_cnt_after got=%0d exp=0", crCnt); end
    crValidIn = 1'b0; crBn = 1'b1;
    advance();
    advance();
    total++; if (crCnt !== 2'd2) begin bad++; $display("[TB] FAIL return_two_credits got=%0d exp=2", crCnt); end
    crValidIn = 1'b1; crDataIn = 16'h2222; crBn = 1'b1;
    advance();
    crValidIn = 1'b0; crBn = 1'b0;
    #1;
    total++; if (crCnt !== 2'd2) begin bad++; $display("[TB] FAIL fire_and_credit_cnt got=%0d exp=2", crCnt); end
    total++; if (crValidOut !== 1'b1) begin bad++; $display("[TB] FAIL fire_and_credit_valid got=%b exp=1", crValidOut); end
    total++; if (crDataOut !== 16'h2222) begin bad++; $display("[TB] FAIL fire_and_credit_data got=%h exp=2222", crDataOut); end
    total++; if (crErr !== 1'b0) begin bad++; $display("[TB] FAIL return_err got=%b exp=0", crErr); end
  endtask

  task automatic test_credit_overflow();
    doReset();
    crValidIn = 1'b1; crDataIn = 16'h3333; crBn = 1'b1;
    advance();
    crValidIn = 1'b0; crBn = 1'b0;
    #1;
    total++; if (crCnt !== 2'd3) begin bad++; $display("[TB] FAIL full_fire_credit_cnt got=%0d exp=3", crCnt); end
    total++; if (crErr !== 1'b0) begin bad++; $display("[TB] FAIL full_fire_credit_err got=%b exp=0", crErr); end
    crBn = 1'b1;
    advance();
    crBn = 1'b0;
    #1;
    total++; if (crErr !== 1'b1) begin bad++; $display("[TB] FAIL overflow_err got=%b exp=1", crErr); end
    total++; if (crCnt !== 2'd3) begin bad++; $display("[TB] FAIL overflow_cnt got=%0d exp=3", crCnt); end
    for (int k = 0; k < 3; k++) begin
      advance();
      total++; if (crErr !== 1'b1) begin bad++; $display("[TB] FAIL overflow_sticky c%0d got=%b exp=1", k, crErr); end
    end
    rst = 1'b1;
    advance();
    rst = 1'b0;
    #1;
    total++; if (crErr !== 1'b0) begin bad++; $display("[TB] FAIL overflow_cleared got=%b exp=0", crErr); end
  endtask

  task automatic test_reset_midstream();
    doReset();
    crValidIn = 1'b1; crDataIn = 16'hAAAA;
    advance();
    crDataIn = 16'hBBBB;
    advance();
    #1;
    total++; if (crCnt !== 2'd1) begin bad++; $display("[TB] FAIL midstream_cnt_before got=%0d exp=1", crCnt); end
    total++; if (crValidOut !== 1'b1) begin bad++; $display("[TB] FAIL midstream_valid_before got=%b exp=1", crValidOut); end
    rst = 1'b1;
    #1;
    total++; if (crReadyOut !== 1'b0) begin bad++; $display("[TB] FAIL midstream_ready_in_rst got=%b exp=0", crReadyOut); end
    advance();
    total++; if (crValidOut !== 1'b0) begin bad++; $display("[TB] FAIL midstream_valid got=%b exp=0", crValidOut); end
    total++; if (crDataOut !== 16'h0000) begin bad++; $display("[TB] FAIL midstream_data got=%h exp=0000", crDataOut); end
    total++; if (crCnt !== 2'd3) begin bad++; $display("[TB] FAIL midstream_cnt got=%0d exp=3", crCnt); end
    rst = 1'b0; crValidIn = 1'b0;
    #1;
    total++; if (crReadyOut !== 1'b1) begin bad++; $display("[TB] FAIL midstream_ready_after got=%b exp=1", crReadyOut); end
  endtask

  task automatic test_credit_comb();
    doReset();
    c0DataIn = 16'h4F4F;
    #1;
    total++; if (c0ValidOut !== 1'b0) begin bad++; $display("[TB] FAIL comb_idle_valid got=%b exp=0", c0ValidOut); end
    c0ValidIn = 1'b1; c0DataIn = 16'h5A5A;
    #1;
    total++; if (c0ValidOut !== 1'b1) begin bad++; $display("[TB] FAIL comb_valid got=%b exp=1", c0ValidOut); end
    total++; if (c0DataOut !== 16'h5A5A) begin bad++; $display("[TB] FAIL comb_data got=%h exp=5a5a", c0DataOut); end
    advance();
    total++; if (c0Cnt !== 2'd2) begin bad++; $display("[TB] FAIL comb_cnt got=%0d exp=2", c0Cnt); end
    advance();
    advance();
    total++; if (c0Cnt !== 2'd0) begin bad++; $display("[TB] FAIL comb_cnt_empty got=%0d exp=0", c0Cnt); end
    total++; if (c0ValidOut !== 1'b0) begin bad++; $display("[TB] FAIL comb_blocked_valid got=%b exp=0", c0ValidOut); end
    c0ValidIn = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Per-cycle offered input, receiver ready, and expected link/ready state.
    logic        offV [0:12] = '{1,1,1,1,1,1,1,1,1,1,1,0,0};
    int          offD [0:12] = '{0,1,2,3,4,4,4,4,5,6,7,0,0};
    logic        bn   [0:12] = '{1,1,1,0,0,0,1,1,1,1,1,1,1};
    logic        expV [0:12] = '{0,1,1,1,1,1,1,1,1,1,1,1,0};
    int          expD [0:12] = '{-1,0,1,2,2,2,2,3,4,5,6,7,-1};
    logic        expR [0:12] = '{1,1,1,1,0,0,0,1,1,1,1,1,1};
    int          rxCount;
    doReset();
    rxCount = 0;
    for (int c = 0; c < 13; c++) begin
      elValidIn = offV[c];
      elDataIn  = 16'h0100 + 16'(offD[c]);
      elBn      = bn[c];
      #1;
      total++; if (elValidOut !== expV[c]) begin bad++; $display("[TB] FAIL elastic_valid c%0d got=%b exp=%b", c, elValidOut, expV[c]); end
      total++; if (elReadyOut !== expR[c]) begin bad++; $display("[TB] FAIL elastic_ready c%0d got=%b exp=%b", c, elReadyOut, expR[c]); end
      if (expD[c] >= 0) begin
        total++;
        if (elDataOut !== 16'h0100 + 16'(expD[c])) begin
          bad++; $display("[TB] FAIL elastic_data c%0d got=%h exp=%h", c, elDataOut, 16'h0100 + 16'(expD[c]));
        end
      end
      if (elValidOut === 1'b1 && elBn === 1'b1) begin
        total++;
        if (elDataOut !== 16'h0100 + 16'(rxCount)) begin
          bad++; $display("[TB] FAIL elastic_order got=%h exp=%h", elDataOut, 16'h0100 + 16'(rxCount));
        end
        rxCount++;
      end
      advance();
    end
    total++; if (rxCount !== 8) begin bad++; $display("[TB] FAIL elastic_count got=%0d exp=8", rxCount); end
    elValidIn = 1'b0; elBn = 1'b0;
  endtask

  task automatic test_passthrough();
    logic        vV [0:3] = '{1, 0, 1, 0};
    logic [15:0] vD [0:3] = '{16'h1234, 16'hABCD, 16'hFFFF, 16'h0F0F};
    logic        vB [0:3] = '{1, 1, 0, 0};
    doReset();
    ptBn = 1'b1;
    rst  = 1'b1;
    #1;
    total++; if (ptReadyOut !== 1'b0) begin bad++; $display("[TB] FAIL pt_ready_in_rst got=%b exp=0", ptReadyOut); end
    rst = 1'b0;
    #1;
    total++; if (ptReadyOut !== 1'b1) begin bad++; $display("[TB] FAIL pt_ready got=%b exp=1", ptReadyOut); end
    for (int i = 0; i < 4; i++) begin
      ptValidIn = vV[i]; ptDataIn = vD[i]; ptBn = vB[i];
      #1;
      total++; if (ptValidOut !== vV[i]) begin bad++; $display("[TB] FAIL pt_valid v%0d got=%b exp=%b", i, ptValidOut, vV[i]); end
      total++; if (ptDataOut !== vD[i]) begin bad++; $display("[TB] FAIL pt_data v%0d got=%h exp=%h", i, ptDataOut, vD[i]); end
      total++; if (ptReadyOut !== vB[i]) begin bad++; $display("[TB] FAIL pt_ready v%0d got=%b exp=%b", i, ptReadyOut, vB[i]); end
    end
    total++; if (ptCnt !== 2'd0) begin bad++; $display("[TB] FAIL pt_cnt got=%0d exp=0", ptCnt); end
    total++; if (ptErr !== 1'b0) begin bad++; $display("[TB] FAIL pt_err got=%b exp=0", ptErr); end
    advance();
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    test_reset();
    test_credit_exhaust();
    test_credit_return();
    test_credit_overflow();
    test_reset_midstream();
    test_credit_comb();
    test_back_to_back();
    test_passthrough();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
